// File: rtl/fix_pkg.sv
// Shared types and sizing for the FIX TX session arbiter and its picker.
package fix_pkg;

    localparam int unsigned HOST_W    = 2;
    localparam int unsigned NUM_HOSTS = 2 ** HOST_W;
    localparam int unsigned MAX_LEN   = 1024;
    localparam int unsigned LEN_W     = 11;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    typedef logic [HOST_W-1:0] host_addr_t;

    // One registered beat toward the TX FIFO
    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        host_addr_t host;
        logic       last;
    } tx_beat_t;

endpackage

// File: rtl/fix_tx_session_arbiter_if.sv
// Session-engine / TOE / TX-FIFO signal bundle for the TX session arbiter.
interface fix_tx_session_arbiter_if;
    import fix_pkg::*;

    logic [NUM_HOSTS-1:0]   req_i;
    logic [NUM_HOSTS*8-1:0] data_i;
    logic [NUM_HOSTS-1:0]   last_i;
    logic [NUM_HOSTS-1:0]   grant_o;
    logic [NUM_HOSTS-1:0]   ready_o;
    logic                   connected_i;
    host_addr_t             connected_host_addr_i;
    logic                   disconnected_i;
    host_addr_t             disconnected_host_addr_i;
    logic                   fifo_full_i;
    logic                   send_message_valid_o;
    logic [7:0]             message_o;
    host_addr_t             message_host_o;
    logic                   message_end_o;
    logic                   abort_o;
    logic [NUM_HOSTS-1:0]   conn_map_o;

    modport slave (
        input  req_i, data_i, last_i, connected_i, connected_host_addr_i,
               disconnected_i, disconnected_host_addr_i, fifo_full_i,
        output grant_o, ready_o, send_message_valid_o, message_o,
               message_host_o, message_end_o, abort_o, conn_map_o
    );

    modport master (
        output req_i, data_i, last_i, connected_i, connected_host_addr_i,
               disconnected_i, disconnected_host_addr_i, fifo_full_i,
        input  grant_o, ready_o, send_message_valid_o, message_o,
               message_host_o, message_end_o, abort_o, conn_map_o
    );

endinterface

// File: rtl/fix_rr_picker.sv
// Round-robin first-eligible search starting at i_rr_ptr and wrapping.
module fix_rr_picker #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] i_eligible,
    input  logic [W-1:0] i_rr_ptr,
    output logic [N-1:0] o_grant_c,
    output logic [W-1:0] o_idx_c,
    output logic         o_any_c
);

    logic [W-1:0] w_cand;

    // Scan from the farthest offset down so the nearest eligible host wins
    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        o_any_c   = 1'b0;
        w_cand    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = i_rr_ptr + W'(k);
            if (i_eligible[w_cand]) begin
                o_grant_c         = '0;
                o_grant_c[w_cand] = 1'b1;
                o_idx_c           = w_cand;
                o_any_c           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fix_tx_session_arbiter.sv
// Shares the TOE TX FIFO byte path between per-host FIX session engines,
// one whole message at a time, round-robin over connected hosts.
module fix_tx_session_arbiter #(
    parameter int unsigned MAX_LEN = fix_pkg::MAX_LEN,
    parameter int unsigned LEN_W   = fix_pkg::LEN_W
) (
    input logic                     clk,
    input logic                     rst,
    fix_tx_session_arbiter_if.slave bus
);
    import fix_pkg::*;

    arb_state_t           r_state,    w_state_nxt;
    host_addr_t           r_owner,    w_owner_nxt;
    host_addr_t           r_rr_ptr,   w_rr_ptr_nxt;
    logic [LEN_W-1:0]     r_cnt,      w_cnt_nxt;
    logic [NUM_HOSTS-1:0] r_grant,    w_grant_nxt;
    logic [NUM_HOSTS-1:0] r_conn_map, w_conn_map_nxt;
    tx_beat_t             r_beat,     w_beat_nxt;
    logic                 r_abort,    w_abort_nxt;

    logic [NUM_HOSTS-1:0] w_eligible, w_pick_grant, w_ready;
    host_addr_t           w_pick_idx;
    logic                 w_pick_any;
    logic                 w_accept, w_last, w_overlen, w_disc_owner, w_kill;
    logic [7:0]           w_byte;

    assign w_eligible   = bus.req_i & r_conn_map;
    assign w_accept     = (r_state == XFER) & bus.req_i[r_owner] & ~bus.fifo_full_i;
    assign w_last       = bus.last_i[r_owner];
    assign w_byte       = bus.data_i[{r_owner, 3'b000} +: 8];
    assign w_overlen    = w_accept & ~w_last & (r_cnt == LEN_W'(MAX_LEN - 1));
    assign w_disc_owner = (r_state == XFER) & bus.disconnected_i
                          & (bus.disconnected_host_addr_i == r_owner);
    assign w_kill       = w_overlen | w_disc_owner;

    fix_rr_picker #(
        .N (NUM_HOSTS),
        .W (HOST_W)
    ) u_picker (
        .i_eligible (w_eligible),
        .i_rr_ptr   (r_rr_ptr),
        .o_grant_c  (w_pick_grant),
        .o_idx_c    (w_pick_idx),
        .o_any_c    (w_pick_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_cnt      <= '0;
            r_grant    <= '0;
            r_conn_map <= '0;
            r_beat     <= '0;
            r_abort    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_grant    <= w_grant_nxt;
            r_conn_map <= w_conn_map_nxt;
            r_beat     <= w_beat_nxt;
            r_abort    <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_cnt_nxt      = r_cnt;
        w_grant_nxt    = r_grant;
        w_conn_map_nxt = r_conn_map;
        w_beat_nxt     = '0;
        w_abort_nxt    = 1'b0;

        // Disconnect applied last so it wins over a same-address connect
        if (bus.connected_i)    w_conn_map_nxt[bus.connected_host_addr_i]    = 1'b1;
        if (bus.disconnected_i) w_conn_map_nxt[bus.disconnected_host_addr_i] = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = XFER;
                    w_owner_nxt = w_pick_idx;
                    w_grant_nxt = w_pick_grant;
                    w_cnt_nxt   = '0;
                end
            end
            XFER: begin
                if (w_accept) begin
                    w_cnt_nxt        = r_cnt + LEN_W'(1);
                    w_beat_nxt.valid = 1'b1;
                    w_beat_nxt.data  = w_byte;
                    w_beat_nxt.host  = r_owner;
                    w_beat_nxt.last  = w_last | w_kill;
                end
                // Normal end or abort both release the path and advance the pointer
                if ((w_accept & w_last) | w_kill) begin
                    w_state_nxt  = IDLE;
                    w_grant_nxt  = '0;
                    w_rr_ptr_nxt = r_owner + HOST_W'(1);
                    w_cnt_nxt    = '0;
                    w_abort_nxt  = w_kill;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_ready          = '0;
        w_ready[r_owner] = w_accept;
    end

    assign bus.grant_o              = r_grant;
    assign bus.ready_o              = w_ready;
    assign bus.send_message_valid_o = r_beat.valid;
    assign bus.message_o            = r_beat.data;
    assign bus.message_host_o       = r_beat.host;
    assign bus.message_end_o        = r_beat.last;
    assign bus.abort_o              = r_abort;
    assign bus.conn_map_o           = r_conn_map;

endmodule
